bus_crossover_fifo: RTL and testbench
=====================================

// Module: bus_crossover_fifo
// PURPOSE
// - Registered pipeline stage placed between two producer/consumer instances of the
//   mixed-range bus model: it consumes a model's o0[2:-2] and o1[-2:2] outputs and
//   drives the next model's i0[2:-2] and i1[-2:2] inputs.
// - Implements the o0->i1 / o1->i0 crossover as a valid/ready FIFO, so the two
//   instances are decoupled in time and protected by back-pressure.
// - Bus ranges stay exactly as declared, with opposite index directions.
// PARAMETERS
// - DEPTH    4   entries; power of two, >= 2
// - MSB_IDX  2   left index of descending buses; ascending buses are [-MSB_IDX:MSB_IDX]
// - (W = 2*MSB_IDX+1 = 5 bits per bus; entry = 2*W bits)
// PORTS
// - clk       in   1                       rising-edge clock
// - rst_n     in   1                       async assert, active-low; deassert synchronised by the top
// - in_valid  in   1                       producer has data
// - in_ready  out  1                       FIFO can accept
// - in_o0     in   [MSB_IDX:-MSB_IDX]      producer o0 (descending)
// - in_o1     in   [-MSB_IDX:MSB_IDX]      producer o1 (ascending)
// - out_valid out  1                       head entry is presented
// - out_ready in   1                       consumer takes the head
// - out_i0    out  [MSB_IDX:-MSB_IDX]      consumer i0, sourced from stored o1
// - out_i1    out  [-MSB_IDX:MSB_IDX]      consumer i1, sourced from stored o0
// - level     out  [$clog2(DEPTH):0]       entries held, including the presented head
// BEHAVIOUR
// - Transfer rules:
//   - push = in_valid & in_ready
//   - pop  = out_valid & out_ready
//   - in_ready = (level != DEPTH); it is combinational from state only, never from out_ready
// - Crossover uses positional, MSB-to-MSB mapping:
//   - out_i1[-2] = o0[2] ... out_i1[2] = o0[-2]
//   - out_i0[2] = o1[-2] ... out_i0[-2] = o1[2]
//   - No bit reversal by index value.
// - Latency: data pushed on edge N is presented on edge N+1 (out_valid=1 from N+1) when
//   the FIFO was empty. No combinational in->out path.
// - Outputs out_valid, out_i0 and out_i1 are registered.
// - The head register holds its value while out_valid & !out_ready. Data is stable under stall.
// - Full: in_ready=0. A push is refused even if a pop occurs in the same cycle, by design.
// - Empty: out_valid=0. out_i0/out_i1 hold the last popped value; they are zero after reset.
// - Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and order is preserved.
// - Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
// - Reset (async, any cycle, including mid-transfer):
//   - pointers, level and out_valid go to 0; out_i0/out_i1 go to 0; in_ready goes to 1
//   - stored entries are discarded
// - Head state machine:
//   - EMPTY -(push)-> VALID
//   - VALID -(pop & level==1 & !push)-> EMPTY
//   - all other VALID cases stay VALID and reload the head on pop
// CONFIGURATION
// - Macro BUS_CROSSOVER_PARITY_EN:
//   - When defined: one even-parity bit is stored per entry (XOR of in_o0, in_o1 at push).
//     It is recomputed on the head at presentation.
//   - Extra output par_err (1 bit), registered, asserted with out_valid if there is a
//     mismatch. It is zero otherwise and zero on reset.
//   - When undefined: no parity storage and no par_err port.
// STRUCTURE
// - Package bus_crossover_pkg:
//   - MSB_IDX_DEF=2, W_DEF=5
//   - typedef logic [2:-2] bus_desc_t; typedef logic [-2:2] bus_asc_t
//   - typedef struct packed {bus_desc_t o0; bus_asc_t o1;} xfer_t
// - One sub-module, bus_crossover_ram: DEPTH x xfer_t register array, with one write port
//   and one async read port. Pointers, level and the head register live in the top.
// TESTING
// - Reset then single push of o0=5'b10011, o1=5'b00110:
//   - out_valid=1 one edge later
//   - out_i1=5'b10011, with out_i1[-2]=1 and out_i1[2]=1
//   - out_i0=5'b00110; level=1
// - Push 4 entries with out_ready=0:
//   - in_ready=0 and level=4
//   - a 5th in_valid is not accepted
//   - after drain, exactly 4 entries emerge in order
// - out_ready=1 and in_valid=1 continuously for 20 words 0..19:
//   - one word per cycle in order
//   - pointers wrap 5 times; no loss or duplication
// - Full FIFO with pop and push attempted in the same cycle:
//   - push refused; level becomes 3; in_ready becomes 1 the next cycle
// - rst_n pulsed low mid-stream with level=2:
//   - out_valid=0, level=0 and out_i0/out_i1=0 immediately, without waiting for clk
// - With BUS_CROSSOVER_PARITY_EN, force a stored bit flip:
//   - par_err=1 together with out_valid
//   - without the macro, the port is absent

Source files
------------

// File: rtl/bus_crossover_pkg.sv
// Shared types for the o0/o1 -> i1/i0 crossover FIFO: mixed-direction bus types,
// the stored transfer layout and the head-register state encoding.
package bus_crossover_pkg;

  localparam int MSB_IDX_DEF = 2;
  localparam int W_DEF       = 2 * MSB_IDX_DEF + 1;

  typedef logic [MSB_IDX_DEF:-MSB_IDX_DEF] bus_desc_t;
  typedef logic [-MSB_IDX_DEF:MSB_IDX_DEF] bus_asc_t;

  typedef struct packed {
    bus_desc_t o0;
    bus_asc_t  o1;
  } xfer_t;

  typedef enum logic {
    HEAD_EMPTY = 1'b0,
    HEAD_VALID = 1'b1
  } head_state_e;

endpackage

// File: rtl/bus_crossover_ram.sv
// Entry storage for bus_crossover_fifo: DEPTH x ENTRY_W register array with one
// synchronous write port and one asynchronous read port. Contents are never reset.
module bus_crossover_ram
  import bus_crossover_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = $bits(xfer_t)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [ENTRY_W-1:0]         rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_crossover_fifo.sv
// Valid/ready FIFO that crosses a producer's o0/o1 buses onto a consumer's i1/i0
// buses, with a registered head. Optional even parity per entry: BUS_CROSSOVER_PARITY_EN.
module bus_crossover_fifo
  import bus_crossover_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MSB_IDX = MSB_IDX_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MSB_IDX:-MSB_IDX]     in_o0,
  input  logic [-MSB_IDX:MSB_IDX]     in_o1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MSB_IDX:-MSB_IDX]     out_i0,
  output logic [-MSB_IDX:MSB_IDX]     out_i1,
  output logic [$clog2(DEPTH):0]      level
`ifdef BUS_CROSSOVER_PARITY_EN
  ,
  output logic                        par_err
`endif
);

  localparam int W  = 2 * MSB_IDX + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef BUS_CROSSOVER_PARITY_EN
  localparam int EW = 2 * W + 1;
`else
  localparam int EW = 2 * W;
`endif

  head_state_e       state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [2*W-1:0]    head_q, head_d;

  logic              push;
  logic              pop;
  logic              load_en;
  logic [EW-1:0]     in_entry;
  logic [EW-1:0]     load_entry;
  logic [EW-1:0]     ram_rdata;
  logic [AW-1:0]     ram_raddr;

  // Entry layout is {[parity,] o0, o1}; plain vector copies keep the mapping positional.
`ifdef BUS_CROSSOVER_PARITY_EN
  assign in_entry = {^{in_o0, in_o1}, in_o0, in_o1};
`else
  assign in_entry = {in_o0, in_o1};
`endif

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (state_q == HEAD_VALID);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;

  // The head slot is still occupied in the array, so the next entry sits one past rd_ptr.
  assign ram_raddr = rd_ptr_q + AW'(1);

  bus_crossover_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_entry),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    load_en    = 1'b0;
    load_entry = ram_rdata;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      HEAD_EMPTY: begin
        if (push) begin
          state_d    = HEAD_VALID;
          load_en    = 1'b1;
          load_entry = in_entry;
        end
      end
      HEAD_VALID: begin
        if (pop) begin
          if (level_q == LW'(1)) begin
            if (push) begin
              // Last entry leaves while a new one arrives: bypass the array.
              load_en    = 1'b1;
              load_entry = in_entry;
            end else begin
              state_d = HEAD_EMPTY;
            end
          end else begin
            load_en = 1'b1;
          end
        end
      end
      default: state_d = HEAD_EMPTY;
    endcase

    if (load_en) begin
      head_d = load_entry[2*W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HEAD_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Stored o0 feeds i1, stored o1 feeds i0.
  assign out_i1 = head_q[2*W-1:W];
  assign out_i0 = head_q[W-1:0];

`ifdef BUS_CROSSOVER_PARITY_EN
  logic par_err_q, par_err_d;

  // Entries carry even parity, so any nonzero XOR over the whole entry is a fault.
  always_comb begin
    par_err_d = par_err_q;
    if (load_en) begin
      par_err_d = ^load_entry;
    end else if (state_d == HEAD_EMPTY) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_bus_crossover_fifo.sv
// Scoreboard bench for bus_crossover_fifo: expected crossed words are queued on accepted
// pushes and compared when the head is popped; status outputs are checked every cycle.
module tb_bus_crossover_fifo;

  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:-2]   in_o0;
  logic [-2:2]   in_o1;
  logic          out_valid;
  logic          out_ready;
  logic [2:-2]   out_i0;
  logic [-2:2]   out_i1;
  logic [2:0]    level;
`ifdef BUS_CROSSOVER_PARITY_EN
  logic          par_err;
`endif

  int            n_checks;
  int            n_pass;
  int            n_popped;
  int            popped0;
  logic [9:0]    last_pop;
  logic [9:0]    sb_q [$];

  bus_crossover_fifo #(
    .DEPTH   (DEPTH),
    .MSB_IDX (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_o0     (in_o0),
    .in_o1     (in_o1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i0    (out_i0),
    .out_i1    (out_i1),
    .level     (level)
`ifdef BUS_CROSSOVER_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check before the edge, update the model at the edge.
  task automatic step(input logic v, input logic [4:0] d0, input logic [4:0] d1,
                      input logic rdy);
    logic       push_m;
    logic       pop_m;
    logic [4:0] e_i0;
    logic [4:0] e_i1;
    logic [9:0] exp;
    in_valid  = v;
    in_o0     = d0;
    in_o1     = d1;
    out_ready = rdy;
    @(negedge clk);
    chk("in_ready",  32'(in_ready),  32'(sb_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    chk("level",     32'(level),     32'(sb_q.size()));
`ifdef BUS_CROSSOVER_PARITY_EN
    chk("par_err",   32'(par_err),   32'(0));
`endif
    push_m = v && (sb_q.size() != DEPTH);
    pop_m  = rdy && (sb_q.size() != 0);
    if (pop_m) begin
      exp = sb_q[0];
      chk("data_i0", 32'(out_i0), 32'(exp[9:5]));
      chk("data_i1", 32'(out_i1), 32'(exp[4:0]));
      last_pop = exp;
      n_popped++;
    end
    @(posedge clk);
    if (pop_m) void'(sb_q.pop_front());
    if (push_m) begin
      e_i0 = d1;
      e_i1 = d0;
      sb_q.push_back({e_i0, e_i1});
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && sb_q.size() != 0; k++) begin
      step(1'b0, 5'd0, 5'd0, 1'b1);
    end
    chk("drained", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_popped  = 0;
    last_pop  = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_o0     = '0;
    in_o1     = '0;
    out_ready = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_level",     32'(level),     32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_i0",    32'(out_i0),    32'(0));
    chk("rst_out_i1",    32'(out_i1),    32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word: latency and positional crossover.
    step(1'b1, 5'b10011, 5'b00110, 1'b0);
    chk("single_valid", 32'(out_valid),  32'(1));
    chk("single_i1",    32'(out_i1),     32'(5'b10011));
    chk("single_i1_m2", 32'(out_i1[-2]), 32'(1));
    chk("single_i1_p2", 32'(out_i1[2]),  32'(1));
    chk("single_i0",    32'(out_i0),     32'(5'b00110));
    chk("single_level", 32'(level),      32'(1));
    step(1'b0, 5'd0, 5'd0, 1'b1);

    // Fill under back-pressure, refuse a fifth word, drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i + 1), 5'(8 + i), 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_level",    32'(level),    32'(4));
    step(1'b1, 5'h1f, 5'h1f, 1'b0);
    chk("full_refused",  32'(level),    32'(4));
    popped0 = n_popped;
    drain();
    chk("drain_cnt", 32'(n_popped - popped0), 32'(4));
    @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'(0));
    chk("hold_i0",    32'(out_i0),    32'(last_pop[9:5]));
    chk("hold_i1",    32'(out_i1),    32'(last_pop[4:0]));
    @(posedge clk);
    #1;

    // Continuous streaming of 20 words.
    popped0 = n_popped;
    for (int i = 0; i < 20; i++) step(1'b1, 5'(i), 5'(31 - i), 1'b1);
    drain();
    chk("stream_cnt", 32'(n_popped - popped0), 32'(20));

    // Full FIFO with simultaneous push attempt and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(16 + i), 5'(3 * i), 1'b0);
    step(1'b1, 5'h15, 5'h0a, 1'b1);
    chk("fullpp_level",    32'(level),    32'(3));
    chk("fullpp_in_ready", 32'(in_ready), 32'(1));
    drain();

    // Asynchronous reset mid-stream with two entries held.
    step(1'b1, 5'h07, 5'h18, 1'b0);
    step(1'b1, 5'h0c, 5'h11, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_level",     32'(level),     32'(0));
    chk("arst_out_i0",    32'(out_i0),    32'(0));
    chk("arst_out_i1",    32'(out_i1),    32'(0));
    chk("arst_in_ready",  32'(in_ready),  32'(1));
    sb_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b1, 5'h09, 5'h12, 1'b1);
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

`ifdef BUS_CROSSOVER_PARITY_EN
    // Corrupt the entry read from the array as it is loaded into the head.
    step(1'b1, 5'd3, 5'd4, 1'b0);
    step(1'b1, 5'd5, 5'd6, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    force dut.ram_rdata = {^{5'd5, 5'd6}, 5'd5, 5'd6 ^ 5'd1};
    @(posedge clk);
    #1;
    release dut.ram_rdata;
    out_ready = 1'b0;
    chk("par_err_set",   32'(par_err),   32'(1));
    chk("par_err_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("par_err_rst",   32'(par_err),   32'(0));
    sb_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
